// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle mult/div sequencer owning the HI/LO pair.
// Optional accumulate ops (madd/maddu) are built when MDU_MADD_EN is defined.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] ScrA,
    input  logic [31:0] ScrB,
    input  logic        MDUse,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_ok;

    logic        op_md, op_mthi, op_mtlo;
    logic [63:0] res_nx;
    logic        ok_nx;
    logic [3:0]  lat_nx;
    logic        issue;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, dvs_s, dvs_u;
    logic [31:0] qm, rm, q_s, r_s, q_u, r_u;

    // Arithmetic for every op, evaluated on the issue operands.
    always_comb begin
        prod_s = $signed({{32{ScrA[31]}}, ScrA}) * $signed({{32{ScrB[31]}}, ScrB});
        prod_u = {32'd0, ScrA} * {32'd0, ScrB};
        a_mag  = ScrA[31] ? -ScrA : ScrA;
        b_mag  = ScrB[31] ? -ScrB : ScrB;
        // A zero divisor never commits; substitute 1 to keep the divider defined.
        dvs_s  = (ScrB == 32'd0) ? 32'd1 : b_mag;
        dvs_u  = (ScrB == 32'd0) ? 32'd1 : ScrB;
        qm     = a_mag / dvs_s;
        rm     = a_mag % dvs_s;
        q_s    = (ScrA[31] ^ ScrB[31]) ? -qm : qm;
        r_s    = ScrA[31] ? -rm : rm;
        q_u    = ScrA / dvs_u;
        r_u    = ScrA % dvs_u;
    end

    // Decode MDOp into the pending result, its latency and commit enable.
    always_comb begin
        op_md   = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        res_nx  = 64'd0;
        ok_nx   = 1'b1;
        lat_nx  = 4'(MULT_CYCLES);
        case (MDOp)
            4'b0001: begin
                op_md  = 1'b1;
                res_nx = prod_s;
            end
            4'b0010: begin
                op_md  = 1'b1;
                res_nx = prod_u;
            end
            4'b0011: begin
                op_md  = 1'b1;
                res_nx = {r_s, q_s};
                ok_nx  = (ScrB != 32'd0);
                lat_nx = 4'(DIV_CYCLES);
            end
            4'b0100: begin
                op_md  = 1'b1;
                res_nx = {r_u, q_u};
                ok_nx  = (ScrB != 32'd0);
                lat_nx = 4'(DIV_CYCLES);
            end
            4'b0101: op_mthi = 1'b1;
            4'b0110: op_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            4'b0111: begin
                op_md  = 1'b1;
                res_nx = {HI, LO} + prod_s;
            end
            4'b1000: begin
                op_md  = 1'b1;
                res_nx = {HI, LO} + prod_u;
            end
`endif
            default: ;
        endcase
    end

    assign issue = Start && (state == IDLE) && op_md;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: leave IDLE on a multi-cycle issue, return on the last count.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (issue) state_nx = RUN;
            RUN:     if (cnt == 4'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counter, pending result and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            pend    <= 64'd0;
            pend_ok <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (state == IDLE) begin
            if (issue) begin
                cnt     <= lat_nx;
                pend    <= res_nx;
                pend_ok <= ok_nx;
            end else if (Start && op_mthi) begin
                HI <= ScrA;
            end else if (Start && op_mtlo) begin
                LO <= ScrA;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && pend_ok) begin
                HI <= pend[63:32];
                LO <= pend[31:0];
            end
        end
    end

    assign Busy  = (state == RUN);
    assign Stall = MDUse & (Start | Busy);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed checks of mdu_sequencer latency, arithmetic,
// move-to ops, ignored issues, stall generation and mid-op reset.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] ScrA, ScrB;
    logic        MDUse;
    logic        Busy, Stall;
    logic [31:0] HI, LO;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    mdu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .ScrA  (ScrA),
        .ScrB  (ScrB),
        .MDUse (MDUse),
        .Busy  (Busy),
        .Stall (Stall),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one Start pulse; Stall is checked combinationally on the Start cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_md);
        Start = 1'b1;
        MDOp  = op;
        ScrA  = a;
        ScrB  = b;
        MDUse = use_md;
        #1;
        chk("stall_start", {31'd0, Stall}, {31'd0, use_md});
        step();
        Start = 1'b0;
        MDOp  = 4'd0;
        ScrA  = 32'hA5A5A5A5;
        ScrB  = 32'h5A5A5A5A;
    endtask

    // Count Busy cycles, bounded; Stall must track MDUse while busy.
    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 40) begin
            chk("stall_busy", {31'd0, Stall}, {31'd0, MDUse});
            cycles++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 4'd0;
        ScrA  = 32'd0;
        ScrB  = 32'd0;
        MDUse = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b0;

        // mult -2 * 3 with MDUse held
        issue(4'b0001, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_busy(n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_stall_after", {31'd0, Stall}, 32'd0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        MDUse = 1'b0;

        // multu 0xFFFFFFFF * 2
        issue(4'b0010, 32'hFFFFFFFF, 32'd2, 1'b0);
        wait_busy(n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        // mult 0x10000 * 0x10000 carries into HI
        issue(4'b0001, 32'h00010000, 32'h00010000, 1'b0);
        wait_busy(n);
        chk("mult2_hi", HI, 32'h00000001);
        chk("mult2_lo", LO, 32'h00000000);

        // div -7 / 2
        issue(4'b0011, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_busy(n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        // divu by zero: full latency, HI/LO untouched
        issue(4'b0100, 32'd1234, 32'd0, 1'b0);
        wait_busy(n);
        chk("divz_cycles", n, 32'd10);
        chk("divz_hi", HI, 32'hFFFFFFFF);
        chk("divz_lo", LO, 32'hFFFFFFFD);

        // mthi in IDLE
        issue(4'b0101, 32'h12345678, 32'd0, 1'b0);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        chk("mthi_hi", HI, 32'h12345678);
        chk("mthi_lo", LO, 32'hFFFFFFFD);

        // div 100 / 7 with an mtlo issued on Busy cycle 3
        issue(4'b0011, 32'd100, 32'd7, 1'b0);
        chk("div2_nostall", {31'd0, Stall}, 32'd0);
        step();
        step();
        Start = 1'b1;
        MDOp  = 4'b0110;
        ScrA  = 32'h0000DEAD;
        step();
        Start = 1'b0;
        MDOp  = 4'd0;
        chk("mtlo_ignored_lo", LO, 32'hFFFFFFFD);
        wait_busy(n);
        chk("div2_cycles", n + 3, 32'd10);
        chk("div2_lo", LO, 32'd14);
        chk("div2_hi", HI, 32'd2);

        // undefined / no-op codes
        issue(4'b0000, 32'd9, 32'd9, 1'b0);
        chk("nop_busy", {31'd0, Busy}, 32'd0);
        issue(4'b1111, 32'd9, 32'd9, 1'b0);
        chk("undef_busy", {31'd0, Busy}, 32'd0);
        chk("undef_lo", LO, 32'd14);

`ifdef MDU_MADD_EN
        issue(4'b0101, 32'd0, 32'd0, 1'b0);
        issue(4'b0110, 32'hFFFFFFFF, 32'd0, 1'b0);
        issue(4'b1000, 32'd1, 32'd1, 1'b0);
        wait_busy(n);
        chk("maddu_cycles", n, 32'd5);
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
        issue(4'b0111, 32'hFFFFFFFF, 32'd1, 1'b0);
        wait_busy(n);
        chk("madd_hi", HI, 32'd0);
        chk("madd_lo", LO, 32'hFFFFFFFF);
`else
        issue(4'b0111, 32'd3, 32'd3, 1'b0);
        chk("madd_off_busy", {31'd0, Busy}, 32'd0);
        issue(4'b1000, 32'd3, 32'd3, 1'b0);
        chk("maddu_off_busy", {31'd0, Busy}, 32'd0);
        chk("madd_off_hi", HI, 32'd2);
        chk("madd_off_lo", LO, 32'd14);
`endif

        // reset on Busy cycle 3 of a div aborts it
        issue(4'b0011, 32'd50, 32'hFFFFFFFD, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (12) step();
        chk("abort_late_busy", {31'd0, Busy}, 32'd0);
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);

        // signed div after reset: 50 / -3
        issue(4'b0011, 32'd50, 32'hFFFFFFFD, 1'b0);
        wait_busy(n);
        chk("div3_lo", LO, 32'hFFFFFFF0);
        chk("div3_hi", HI, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
